// File: rtl/busca_maior_pkg.sv
// rtl/busca_maior_pkg.sv - shared widths, frame limit and FSM state encoding for busca_maior
package busca_maior_pkg;

    localparam int DATA_W       = 8;
    localparam int CNT_W        = 8;
    localparam int MAX_AMOSTRAS = 255;

    typedef enum logic {
        COLETA  = 1'b0,
        ENTREGA = 1'b1
    } estado_t;

endpackage

// File: rtl/busca_maior_if.sv
// rtl/busca_maior_if.sv - sample-in / result-out handshake bundle for busca_maior
interface busca_maior_if;
    import busca_maior_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_max;
    logic [CNT_W-1:0]  out_idx;
    logic [CNT_W-1:0]  out_rep;

    // Block side: consumes samples, produces the frame result
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_max, out_idx, out_rep
    );

    // Environment side: produces samples, consumes the frame result
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_max, out_idx, out_rep
    );

endinterface

// File: rtl/busca_maior_cmp.sv
// rtl/busca_maior_cmp.sv - 8-bit tree comparator, flags a>b (M) and a==b (I)
module busca_maior_cmp
    import busca_maior_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_m,
    output logic              o_i
);

    logic [7:0] w_g0, w_e0;
    logic [3:0] w_g1, w_e1;
    logic [1:0] w_g2, w_e2;

    // Bit-level flags merged pairwise: the upper half decides unless it is equal
    always_comb begin
        w_g0 = i_a & ~i_b;
        w_e0 = ~(i_a ^ i_b);
        for (int k = 0; k < 4; k++) begin
            w_g1[k] = w_g0[2*k+1] | (w_e0[2*k+1] & w_g0[2*k]);
            w_e1[k] = w_e0[2*k+1] & w_e0[2*k];
        end
        for (int k = 0; k < 2; k++) begin
            w_g2[k] = w_g1[2*k+1] | (w_e1[2*k+1] & w_g1[2*k]);
            w_e2[k] = w_e1[2*k+1] & w_e1[2*k];
        end
        o_m = w_g2[1] | (w_e2[1] & w_g2[0]);
        o_i = w_e2[1] & w_e2[0];
    end

endmodule

// File: rtl/busca_maior.sv
// rtl/busca_maior.sv - streaming frame max-finder: maximum, first index and repetition count
module busca_maior
    import busca_maior_pkg::*;
#(
    parameter int N_AMOSTRAS = 8
)(
    input  logic         clk,
    input  logic         rst,
    busca_maior_if.slave bus
);

    if (N_AMOSTRAS < 1 || N_AMOSTRAS > MAX_AMOSTRAS) begin : g_bad_n_amostras
        $error("busca_maior: N_AMOSTRAS out of range 1..255");
    end

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_AMOSTRAS - 1);

    estado_t           r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_max;
    logic [CNT_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_rep;
    logic              r_in_ready;
    logic              r_out_valid;

    logic              w_m;
    logic              w_i;
    logic              w_accept;

    busca_maior_cmp u_cmp (
        .i_a (bus.in_data),
        .i_b (r_max),
        .o_m (w_m),
        .o_i (w_i)
    );

    assign w_accept = bus.in_valid & r_in_ready;

    // Frame FSM with counter and max/idx/rep bank; handshake outputs are registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= COLETA;
            r_cnt       <= '0;
            r_max       <= '0;
            r_idx       <= '0;
            r_rep       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                COLETA: begin
                    if (w_accept) begin
                        if (r_cnt == '0 || w_m) begin
                            // First sample of a frame or a strictly larger one restarts the tally
                            r_max <= bus.in_data;
                            r_idx <= r_cnt;
                            r_rep <= CNT_W'(1);
                        end else if (w_i) begin
                            // Equal sample: keep the earliest index, only count the repeat
                            r_rep <= r_rep + CNT_W'(1);
                        end
                        if (r_cnt == LAST_CNT) begin
                            r_cnt       <= '0;
                            r_state     <= ENTREGA;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ENTREGA: begin
                    if (bus.out_ready) begin
                        r_state     <= COLETA;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= COLETA;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_max   = r_max;
    assign bus.out_idx   = r_idx;
    assign bus.out_rep   = r_rep;

endmodule

// File: tb/tb_busca_maior.sv
// tb/tb_busca_maior.sv - directed and model-checked bench for busca_maior at N_AMOSTRAS 8, 1 and 255
module tb_busca_maior;

    logic clk;
    logic rst;

    busca_maior_if if8 ();
    busca_maior_if if1 ();
    busca_maior_if if255 ();

    busca_maior #(.N_AMOSTRAS(8))   dut8   (.clk(clk), .rst(rst), .bus(if8));
    busca_maior #(.N_AMOSTRAS(1))   dut1   (.clk(clk), .rst(rst), .bus(if1));
    busca_maior #(.N_AMOSTRAS(255)) dut255 (.clk(clk), .rst(rst), .bus(if255));

    int         sel;
    logic       drv_valid;
    logic [7:0] drv_data;
    logic       drv_out_ready;

    logic       obs_in_ready;
    logic       obs_out_valid;
    logic [7:0] obs_max;
    logic [7:0] obs_idx;
    logic [7:0] obs_rep;

    int         n_cmp;
    int         n_bad;
    logic [7:0] stim [0:254];

    assign if8.in_valid    = (sel == 0) & drv_valid;
    assign if8.in_data     = drv_data;
    assign if8.out_ready   = (sel == 0) & drv_out_ready;
    assign if1.in_valid    = (sel == 1) & drv_valid;
    assign if1.in_data     = drv_data;
    assign if1.out_ready   = (sel == 1) & drv_out_ready;
    assign if255.in_valid  = (sel == 2) & drv_valid;
    assign if255.in_data   = drv_data;
    assign if255.out_ready = (sel == 2) & drv_out_ready;

    always_comb begin
        obs_in_ready  = if8.in_ready;
        obs_out_valid = if8.out_valid;
        obs_max       = if8.out_max;
        obs_idx       = if8.out_idx;
        obs_rep       = if8.out_rep;
        if (sel == 1) begin
            obs_in_ready  = if1.in_ready;
            obs_out_valid = if1.out_valid;
            obs_max       = if1.out_max;
            obs_idx       = if1.out_idx;
            obs_rep       = if1.out_rep;
        end else if (sel == 2) begin
            obs_in_ready  = if255.in_ready;
            obs_out_valid = if255.out_valid;
            obs_max       = if255.out_max;
            obs_idx       = if255.out_idx;
            obs_rep       = if255.out_rep;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Present stim[0..n-1] with bubble_pct percent idle cycles; returns at posedge+1 after the last accept
    task automatic feed(input int n, input int bubble_pct);
        int   i;
        int   budget;
        logic v;
        logic rdy;
        i = 0;
        budget = 0;
        while (i < n && budget < 40 * n + 100) begin
            v = ($urandom_range(0, 99) >= bubble_pct);
            drv_valid = v;
            drv_data  = stim[i];
            rdy = obs_in_ready;
            @(posedge clk);
            #1;
            budget++;
            if (v && rdy) i++;
        end
        drv_valid = 1'b0;
        if (i < n) check_eq("feed_timeout", i, n);
    endtask

    task automatic check_result(input string tag, input int m, input int x, input int r);
        check_eq({tag, "_out_valid"}, obs_out_valid, 1);
        check_eq({tag, "_in_ready"},  obs_in_ready,  0);
        check_eq({tag, "_max"},       obs_max,       m);
        check_eq({tag, "_idx"},       obs_idx,       x);
        check_eq({tag, "_rep"},       obs_rep,       r);
    endtask

    task automatic release_result(input string tag, input int waits);
        drv_out_ready = 1'b0;
        repeat (waits) begin
            @(posedge clk);
            #1;
        end
        if (waits > 0) check_eq({tag, "_hold_valid"}, obs_out_valid, 1);
        drv_out_ready = 1'b1;
        @(posedge clk);
        #1;
        drv_out_ready = 1'b0;
        check_eq({tag, "_rel_valid"}, obs_out_valid, 0);
        check_eq({tag, "_rel_ready"}, obs_in_ready,  1);
    endtask

    task automatic load8(input logic [63:0] v);
        for (int k = 0; k < 8; k++) stim[k] = v[63 - 8*k -: 8];
    endtask

    initial begin
        int n;
        int bub;
        int mx;
        int fi;
        int ct;
        int lim;

        n_cmp = 0;
        n_bad = 0;
        sel = 0;
        drv_valid = 1'b0;
        drv_data = 8'd0;
        drv_out_ready = 1'b0;
        rst = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready",  obs_in_ready,  1);
        check_eq("rst_out_valid", obs_out_valid, 0);
        check_eq("rst_max",       obs_max,       0);
        check_eq("rst_idx",       obs_idx,       0);
        check_eq("rst_rep",       obs_rep,       0);
        rst = 1'b0;

        // Mixed frame, back-to-back; check lands one cycle after the last accept
        load8({8'd10, 8'd20, 8'd20, 8'd5, 8'd20, 8'd1, 8'd0, 8'd19});
        feed(8, 0);
        check_result("t1", 20, 1, 3);
        release_result("t1", 0);

        // Descending frame
        load8({8'd255, 8'd254, 8'd253, 8'd252, 8'd251, 8'd250, 8'd249, 8'd248});
        feed(8, 0);
        check_result("t2a", 255, 0, 1);
        release_result("t2a", 1);

        // All-zero frame
        load8(64'd0);
        feed(8, 0);
        check_result("t2b", 0, 0, 8);
        release_result("t2b", 0);

        // Backpressure: result held while samples wait at the input
        load8({8'd7, 8'd3, 8'd9, 8'd9, 8'd2, 8'd1, 8'd9, 8'd4});
        feed(8, 0);
        check_result("t3a", 9, 2, 3);
        load8({8'd50, 8'd9, 8'd2, 8'd9, 8'd1, 8'd0, 8'd4, 8'd7});
        drv_valid = 1'b1;
        drv_data  = stim[0];
        drv_out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check_result("t3_hold", 9, 2, 3);
        end
        drv_out_ready = 1'b1;
        @(posedge clk);
        #1;
        drv_out_ready = 1'b0;
        check_eq("t3_rel_valid", obs_out_valid, 0);
        check_eq("t3_rel_ready", obs_in_ready,  1);
        check_eq("t3_rel_max",   obs_max,       9);
        feed(8, 0);
        check_result("t3b", 50, 0, 1);
        release_result("t3b", 0);

        // Reset between clock edges after a partial frame
        load8({8'd100, 8'd200, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0});
        feed(4, 0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t4_rst_max",   obs_max,       0);
        check_eq("t4_rst_idx",   obs_idx,       0);
        check_eq("t4_rst_rep",   obs_rep,       0);
        check_eq("t4_rst_valid", obs_out_valid, 0);
        check_eq("t4_rst_ready", obs_in_ready,  1);
        #1;
        rst = 1'b0;
        load8({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8});
        feed(8, 0);
        check_result("t4", 8, 7, 1);
        release_result("t4", 0);

        // Test 1 data with idle bubbles
        load8({8'd10, 8'd20, 8'd20, 8'd5, 8'd20, 8'd1, 8'd0, 8'd19});
        feed(8, 40);
        check_result("t5", 20, 1, 3);
        release_result("t5", 2);

        // Random frames across the three frame sizes against a behavioural model
        for (int f = 0; f < 1000; f++) begin
            if (f % 20 == 0) begin
                sel = 2;
                n = 255;
            end else if (f % 2 == 1) begin
                sel = 1;
                n = 1;
            end else begin
                sel = 0;
                n = 8;
            end
            lim = (f % 3 == 0) ? 3 : 255;
            for (int k = 0; k < n; k++) stim[k] = 8'($urandom_range(0, lim));
            mx = -1;
            fi = 0;
            ct = 0;
            for (int k = 0; k < n; k++) begin
                if (int'(stim[k]) > mx) begin
                    mx = int'(stim[k]);
                    fi = k;
                    ct = 1;
                end else if (int'(stim[k]) == mx) begin
                    ct++;
                end
            end
            bub = $urandom_range(0, 30);
            feed(n, bub);
            check_result("t6", mx, fi, ct);
            release_result("t6", $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
